// File: rtl/uart_tx_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo_if
//   Producer-side bus of the FIFO-fronted UART transmitter.
//   master : the byte producer (drives tx_val, tx_data, ovf_clr)
//   slave  : the transmitter  (drives tx_rdy, overflow, fifo_count)
//   Signals:
//     tx_val     write strobe, word accepted when tx_val && tx_rdy
//     tx_data    word to send (DATA_BITS wide)
//     tx_rdy     FIFO not full
//     ovf_clr    clears the sticky overflow flag
//     overflow   a write was attempted while the FIFO was full
//     fifo_count words currently held in the FIFO
// ---------------------------------------------------------------------------
interface uart_tx_fifo_if #(
  parameter int DATA_BITS = 8,
  parameter int DEPTH     = 4
);
  logic                     tx_val;
  logic [DATA_BITS-1:0]     tx_data;
  logic                     tx_rdy;
  logic                     ovf_clr;
  logic                     overflow;
  logic [$clog2(DEPTH):0]   fifo_count;

  modport master (
    output tx_val, tx_data, ovf_clr,
    input  tx_rdy, overflow, fifo_count
  );

  modport slave (
    input  tx_val, tx_data, ovf_clr,
    output tx_rdy, overflow, fifo_count
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
//   Parametrised UART transmitter with an input FIFO. Frames are
//   start | DATA_BITS data bits (LSB first) | optional parity | STOP_BITS stop,
//   one bit per pulse_tx strobe. Queued words go out back-to-back with no
//   idle gap between frames.
//   Ports:
//     clk       system clock
//     rst       synchronous, active-high reset
//     pulse_tx  one-clock baud strobe, one per bit period
//     bus       producer bus (slave side): tx_val/tx_data/tx_rdy,
//               ovf_clr/overflow, fifo_count
//     tx        registered serial line, idles high
//     busy      high while a frame is on the line
//   Parameters:
//     DATA_BITS 5..9, PARITY 0=none/1=odd/2=even, STOP_BITS 1 or 2,
//     DEPTH power of two >= 2
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pulse_tx,
  uart_tx_fifo_if.slave         bus,
  output logic                  tx,
  output logic                  busy
);

  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = AW + 1;
  localparam int BCW = $clog2(DATA_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  // -------------------------------------------------------------------------
  // FIFO storage and pointers
  // -------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;
  logic          overflow_q, overflow_d;

  logic push;
  logic pop;
  logic full;
  logic not_empty;

  assign full      = (count_q == CW'(DEPTH));
  assign not_empty = (count_q != '0);
  assign push      = bus.tx_val && !full;

  // Write-only RAM port; the read side is captured by the shift register
  // load, so the head word is only ever consumed through a flop.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q] <= bus.tx_data;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // A dropped write outranks a clear in the same cycle.
    if (bus.tx_val && full) begin
      overflow_d = 1'b1;
    end else if (bus.ovf_clr) begin
      overflow_d = 1'b0;
    end
  end

  assign bus.tx_rdy     = !full;
  assign bus.overflow   = overflow_q;
  assign bus.fifo_count = count_q;

  // -------------------------------------------------------------------------
  // Transmit FSM
  // -------------------------------------------------------------------------
  state_t               state_q,   state_d;
  logic [DATA_BITS-1:0] shift_q,   shift_d;
  logic [BCW-1:0]       bit_cnt_q, bit_cnt_d;
  logic                 stop_cnt_q, stop_cnt_d;
  logic                 par_q,     par_d;
  logic                 tx_q,      tx_d;
  logic                 busy_q,    busy_d;

  logic                 load;
  logic [DATA_BITS-1:0] head_word;
  logic                 head_xor;

  assign head_word = mem[rd_ptr_q];
  assign head_xor  = ^head_word;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    par_d      = par_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    load       = 1'b0;

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (pulse_tx && not_empty) begin
          load = 1'b1;
        end
      end

      START: begin
        if (pulse_tx) begin
          tx_d      = shift_q[0];
          shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = '0;
          state_d   = DATA;
        end
      end

      DATA: begin
        if (pulse_tx) begin
          if (bit_cnt_q == BCW'(DATA_BITS - 1)) begin
            if (PARITY != 0) begin
              tx_d    = par_q;
              state_d = PAR;
            end else begin
              tx_d       = 1'b1;
              stop_cnt_d = 1'b0;
              state_d    = STOP;
            end
          end else begin
            tx_d      = shift_q[0];
            shift_d   = {1'b0, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end
      end

      PAR: begin
        if (pulse_tx) begin
          tx_d       = 1'b1;
          stop_cnt_d = 1'b0;
          state_d    = STOP;
        end
      end

      STOP: begin
        if (pulse_tx) begin
          if (stop_cnt_q == 1'(STOP_BITS - 1)) begin
            // End of the last stop bit: chain straight into the next
            // frame when a word is waiting, otherwise fall idle.
            if (not_empty) begin
              load = 1'b1;
            end else begin
              tx_d    = 1'b1;
              busy_d  = 1'b0;
              state_d = IDLE;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end

      default: begin
        tx_d    = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase

    // Frame start shared by IDLE and back-to-back STOP: take the head word
    // and freeze its parity so later FIFO traffic cannot affect this frame.
    if (load) begin
      shift_d = head_word;
      par_d   = (PARITY == 1) ? ~head_xor : head_xor;
      tx_d    = 1'b0;
      busy_d  = 1'b1;
      state_d = START;
    end
  end

  assign pop = load;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      par_q      <= par_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
//   Three transmitter instances sharing clk/rst/pulse_tx:
//     A: 8 data, no parity, 1 stop   (defaults, FIFO/overflow/reset tests)
//     B: 8 data, even parity, 2 stop
//     C: 7 data, odd parity, 1 stop
//   Expected line bits are queued when words are written and popped one per
//   pulse_tx as the selected instance puts bits on the line.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

  logic clk;
  logic rst;
  logic pulse_tx;

  logic tx_a, busy_a;
  logic tx_b, busy_b;
  logic tx_c, busy_c;

  uart_tx_fifo_if #(.DATA_BITS(8), .DEPTH(4)) bus_a ();
  uart_tx_fifo_if #(.DATA_BITS(8), .DEPTH(4)) bus_b ();
  uart_tx_fifo_if #(.DATA_BITS(7), .DEPTH(4)) bus_c ();

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DEPTH(4)) dut_a (
    .clk      (clk),
    .rst      (rst),
    .pulse_tx (pulse_tx),
    .bus      (bus_a.slave),
    .tx       (tx_a),
    .busy     (busy_a)
  );

  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .DEPTH(4)) dut_b (
    .clk      (clk),
    .rst      (rst),
    .pulse_tx (pulse_tx),
    .bus      (bus_b.slave),
    .tx       (tx_b),
    .busy     (busy_b)
  );

  uart_tx_fifo #(.DATA_BITS(7), .PARITY(1), .STOP_BITS(1), .DEPTH(4)) dut_c (
    .clk      (clk),
    .rst      (rst),
    .pulse_tx (pulse_tx),
    .bus      (bus_c.slave),
    .tx       (tx_c),
    .busy     (busy_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int sel      = 0;

  logic       obs_tx, obs_busy, obs_rdy, obs_ovf;
  logic [2:0] obs_cnt;

  always_comb begin
    obs_tx   = tx_a;
    obs_busy = busy_a;
    obs_rdy  = bus_a.tx_rdy;
    obs_ovf  = bus_a.overflow;
    obs_cnt  = bus_a.fifo_count;
    case (sel)
      1: begin
        obs_tx = tx_b; obs_busy = busy_b; obs_rdy = bus_b.tx_rdy;
        obs_ovf = bus_b.overflow; obs_cnt = bus_b.fifo_count;
      end
      2: begin
        obs_tx = tx_c; obs_busy = busy_c; obs_rdy = bus_c.tx_rdy;
        obs_ovf = bus_c.overflow; obs_cnt = bus_c.fifo_count;
      end
      default: ;
    endcase
  end

  logic sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Expected line bits for one frame, built from the framing rules.
  task automatic sb_frame(input logic [8:0] w, input int nbits, input int par, input int stops);
    logic p;
    p = 1'b0;
    sb.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin
      sb.push_back(w[i]);
      p = p ^ w[i];
    end
    if (par == 1) sb.push_back(~p);
    if (par == 2) sb.push_back(p);
    for (int i = 0; i < stops; i++) sb.push_back(1'b1);
  endtask

  task automatic wr(input logic [8:0] d);
    @(negedge clk);
    case (sel)
      0: begin bus_a.tx_val = 1'b1; bus_a.tx_data = d[7:0]; end
      1: begin bus_b.tx_val = 1'b1; bus_b.tx_data = d[7:0]; end
      default: begin bus_c.tx_val = 1'b1; bus_c.tx_data = d[6:0]; end
    endcase
  endtask

  // Ends a write burst and scribbles the data lines.
  task automatic wr_end();
    @(negedge clk);
    bus_a.tx_val = 1'b0; bus_b.tx_val = 1'b0; bus_c.tx_val = 1'b0;
    bus_a.tx_data = 8'hFF; bus_b.tx_data = 8'hFF; bus_c.tx_data = 7'h7F;
  endtask

  task automatic do_pulse();
    @(negedge clk);
    pulse_tx = 1'b1;
    @(negedge clk);
    pulse_tx = 1'b0;
  endtask

  task automatic run_sb(input string tag);
    logic e;
    int   k;
    k = 0;
    while (sb.size() > 0) begin
      do_pulse();
      e = sb.pop_front();
      chk($sformatf("%s tx bit %0d", tag, k), obs_tx, e);
      chk($sformatf("%s busy bit %0d", tag, k), obs_busy, 1'b1);
      $display("%s: bit %0d tx=%0b busy=%0b", tag, k, obs_tx, obs_busy);
      k++;
    end
  endtask

  task automatic idle_chk(input string tag);
    do_pulse();
    chk({tag, " idle tx"}, obs_tx, 1'b1);
    chk({tag, " idle busy"}, obs_busy, 1'b0);
    chk({tag, " idle count"}, obs_cnt, 3'd0);
    $display("%s: idle tx=%0b busy=%0b count=%0d", tag, obs_tx, obs_busy, obs_cnt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    pulse_tx = 1'b0;
    bus_a.tx_val = 1'b0; bus_a.tx_data = '0; bus_a.ovf_clr = 1'b0;
    bus_b.tx_val = 1'b0; bus_b.tx_data = '0; bus_b.ovf_clr = 1'b0;
    bus_c.tx_val = 1'b0; bus_c.tx_data = '0; bus_c.ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset values
    sel = 0;
    chk("reset tx", tx_a, 1'b1);
    chk("reset busy", busy_a, 1'b0);
    chk("reset tx_rdy", bus_a.tx_rdy, 1'b1);
    chk("reset overflow", bus_a.overflow, 1'b0);
    chk("reset count", bus_a.fifo_count, 3'd0);
    chk("reset tx_b", tx_b, 1'b1);
    chk("reset tx_c", tx_c, 1'b1);
    $display("reset: tx=%0b busy=%0b rdy=%0b ovf=%0b cnt=%0d",
             tx_a, busy_a, bus_a.tx_rdy, bus_a.overflow, bus_a.fifo_count);

    // 1: single 8N1 frame
    sel = 0;
    wr(9'h0AC); sb_frame(9'h0AC, 8, 0, 1); wr_end();
    chk("t1 count after push", obs_cnt, 3'd1);
    chk("t1 rdy after push", obs_rdy, 1'b1);
    run_sb("t1");
    idle_chk("t1");

    // 2: 8E2 frame
    sel = 1;
    wr(9'h0AC); sb_frame(9'h0AC, 8, 2, 2); wr_end();
    run_sb("t2");
    idle_chk("t2");

    // 3: back-to-back 8N1
    sel = 0;
    wr(9'h0AC); sb_frame(9'h0AC, 8, 0, 1);
    wr(9'h035); sb_frame(9'h035, 8, 0, 1);
    wr_end();
    chk("t3 count after push", obs_cnt, 3'd2);
    run_sb("t3");
    idle_chk("t3");

    // 4: overflow with pulse_tx held low; only the first DEPTH words land
    sel = 0;
    for (int i = 1; i <= 6; i++) begin
      wr(9'(i));
      if (i <= 4) sb_frame(9'(i), 8, 0, 1);
    end
    wr_end();
    chk("t4 count full", obs_cnt, 3'd4);
    chk("t4 rdy full", obs_rdy, 1'b0);
    chk("t4 overflow set", obs_ovf, 1'b1);
    $display("t4: cnt=%0d rdy=%0b ovf=%0b", obs_cnt, obs_rdy, obs_ovf);
    run_sb("t4");
    idle_chk("t4");
    chk("t4 overflow sticky", obs_ovf, 1'b1);
    @(negedge clk); bus_a.ovf_clr = 1'b1;
    @(negedge clk); bus_a.ovf_clr = 1'b0;
    chk("t4 overflow cleared", obs_ovf, 1'b0);
    $display("t4: after ovf_clr ovf=%0b", obs_ovf);

    // 5: reset during DATA bit 3 with two words queued
    sel = 0;
    wr(9'h0AC); wr(9'h0AD); wr(9'h0AE); wr_end();
    sb.push_back(1'b0);
    sb.push_back(1'b0); sb.push_back(1'b0); sb.push_back(1'b1); sb.push_back(1'b1);
    run_sb("t5");
    chk("t5 count before rst", obs_cnt, 3'd2);
    @(negedge clk); rst = 1'b1; pulse_tx = 1'b1;
    @(negedge clk); rst = 1'b0; pulse_tx = 1'b0;
    chk("t5 tx after rst", obs_tx, 1'b1);
    chk("t5 busy after rst", obs_busy, 1'b0);
    chk("t5 count after rst", obs_cnt, 3'd0);
    chk("t5 rdy after rst", obs_rdy, 1'b1);
    $display("t5: after rst tx=%0b busy=%0b cnt=%0d rdy=%0b", obs_tx, obs_busy, obs_cnt, obs_rdy);
    for (int i = 0; i < 12; i++) begin
      do_pulse();
      chk($sformatf("t5 quiet tx %0d", i), obs_tx, 1'b1);
      chk($sformatf("t5 quiet busy %0d", i), obs_busy, 1'b0);
    end
    $display("t5: line quiet for 12 periods");

    // 6: 7 data bits, odd parity
    sel = 2;
    wr(9'h055); sb_frame(9'h055, 7, 1, 1); wr_end();
    run_sb("t6");
    idle_chk("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Parametrised UART transmitter that succeeds the fixed 8N1 transmitter. It adds configurable data width, parity mode and stop-bit count, plus an input FIFO so that frames go out back-to-back. Bit timing comes from the existing baudgen pulse_tx strobe. The block sits between a byte producer (e.g. an echo path fed from UART_Rx rx_data/rx_val) and the serial tx pin.

Parameters:
DATA_BITS, 8, data bits per frame (5..9).
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame (1 or 2).
DEPTH, 4, FIFO entries; must be a power of 2, at least 2.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
pulse_tx  in  1  one-clk-wide baud strobe, one per bit period (from baudgen).
tx_val  in  1  write strobe; data is accepted when tx_val=1 and tx_rdy=1.
tx_data  in  DATA_BITS  word to send.
tx_rdy  out  1  FIFO not full.
ovf_clr  in  1  clears the overflow flag.
overflow  out  1  sticky flag: a write was attempted while the FIFO was full.
fifo_count  out  $clog2(DEPTH)+1  number of words currently in the FIFO.
tx  out  1  serial line; idles high.
busy  out  1  high while a frame is on the line.

Behaviour:
- Reset values: tx=1, busy=0, tx_rdy=1, overflow=0, fifo_count=0. FSM goes to IDLE; FIFO pointers are cleared. If reset arrives mid-frame, the frame is abandoned, tx=1 from the next edge, and queued data is discarded.
- FIFO:
  - Push on the tx_val && tx_rdy edge; fifo_count increments.
  - tx_rdy = (fifo_count != DEPTH), decoded from registered state.
  - A write while full is dropped and sets overflow on the next edge.
  - overflow holds until ovf_clr or rst. If ovf_clr and a new overflow happen in the same cycle, the set wins.
  - Simultaneous push and pop leaves fifo_count unchanged.
  - Pointers wrap modulo DEPTH.
  - A word pushed in cycle N is poppable from cycle N+1.
- FSM states: IDLE, START, DATA, PAR, STOP. All state transitions occur only on cycles where pulse_tx=1. tx is registered.
  - IDLE: on pulse_tx with fifo_count != 0, pop the head into the shift register, drive tx=0 and go to START; busy=1 from the same edge. With the FIFO empty, stay in IDLE with tx=1.
  - START -> DATA on pulse_tx: drive tx=shift[0], LSB first, bit counter = 0.
  - DATA: each pulse_tx shifts the next bit out. After DATA_BITS bits, go to PAR if PARITY!=0, otherwise to STOP, driving tx=1.
  - Parity bit: even = XOR of the data bits; odd = its inverse. It is computed from the word at load time.
  - STOP: holds tx=1 for STOP_BITS pulse_tx periods.
  - On the pulse_tx that ends the last stop bit:
    - FIFO non-empty: pop, drive tx=0 and go to START. No idle gap; busy stays 1.
    - FIFO empty: go to IDLE, busy=0.
- Frame length is 1 + DATA_BITS + (PARITY!=0) + STOP_BITS bit periods.
- A change on tx_data after acceptance has no effect on the frame in flight or the queued words.
- pulse_tx is ignored in the cycle it coincides with rst.

Test Plan:
1. Defaults (8N1): push 8'hAC on one cycle. Required: after the next pulse_tx, tx sequence per bit period is 0 | 0,0,1,1,0,1,0,1 | 1. busy is high for exactly 10 pulse_tx periods, then fifo_count=0 and busy=0.
2. PARITY=2, STOP_BITS=2: push 8'hAC. Required: tx = 0 | 0,0,1,1,0,1,0,1 | 0 | 1,1 (12 periods). With PARITY=1 the parity bit is 1.
3. Back-to-back, 8N1: push 8'hAC then 8'h35 on consecutive cycles. Required: the stop bit of the first frame is followed immediately by the start bit of the 8'h35 frame (1,0,1,0,1,1,0,0 LSB first). busy never drops between frames: 20 periods high.
4. Overflow, DEPTH=4: with pulse_tx held low, push 6 words 8'h01..8'h06 on consecutive cycles. Required: fifo_count=4, tx_rdy=0, overflow=1. Once pulse_tx is enabled, exactly 8'h01..8'h04 are transmitted. ovf_clr then returns overflow to 0.
5. Reset mid-frame: assert rst for 1 cycle during DATA bit 3 of 8'hAC with 2 words queued. Required: next edge tx=1, busy=0, fifo_count=0, tx_rdy=1, and no further frames.
6. DATA_BITS=7, PARITY=1: push 7'h55. Required: tx = 0 | 1,0,1,0,1,0,1 | 1 | 1 (odd parity bit = 1, four ones in the data).
